// File: rtl/pipe_sched_pkg.sv
// Shared types and helpers for the pipeline scheduler.
package pipe_sched_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAINING = 2'd1,
        DRAINED  = 2'd2
    } state_e;

    // Owner-tag width; at least one bit even for a single requester.
    function automatic int unsigned tag_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from last+1, wrapping, and grants the first active request.
module rr_arbiter
    import pipe_sched_pkg::*;
#(
    parameter  int unsigned NREQ = 2,
    localparam int unsigned TW   = tag_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic            enable,
    input  logic [TW-1:0]   last,
    output logic [NREQ-1:0] grant,
    output logic [TW-1:0]   grant_idx
);

    int unsigned   cand;
    logic [TW-1:0] cand_idx;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand     = (32'(last) + k) % NREQ;
            cand_idx = TW'(cand);
            if (enable && !found && req[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_sched.sv
// Arbitration, valid/owner tracking, stall and drain control for a shared stallable pipeline.
module pipe_sched
    import pipe_sched_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned NREQ  = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ-1:0][XLEN-1:0]    req_data,
    output logic [NREQ-1:0]              req_ready,
    output logic [XLEN-1:0]              pipe_data_in,
    output logic                         pipe_stall,
    input  logic [XLEN-1:0]              pipe_data_out,
    output logic [NREQ-1:0]              resp_valid,
    output logic [XLEN-1:0]              resp_data,
    input  logic [NREQ-1:0]              resp_ready,
    input  logic                         flush,
    input  logic                         drain_req,
    output logic                         drained,
    output logic [$clog2(DEPTH+1)-1:0]   inflight
);

    localparam int unsigned TW = tag_width(NREQ);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    state_e                      state;
    logic [DEPTH-1:0]            v, v_nxt;
    logic [DEPTH-1:0][TW-1:0]    own, own_nxt;
    logic [TW-1:0]               rr;
    logic [TW-1:0]               win_idx;
    logic [XLEN-1:0]             held;
    logic [CW-1:0]               cnt_nxt;
    logic                        head_ready;
    logic                        grant_en;
    logic                        xfer;

    assign head_ready = resp_ready[own[DEPTH-1]];
    assign pipe_stall = v[DEPTH-1] & ~head_ready & ~flush;
    assign grant_en   = (state == RUN) & ~drain_req & ~pipe_stall & ~flush;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .enable    (grant_en),
        .last      (rr),
        .grant     (req_ready),
        .grant_idx (win_idx)
    );

    // Grant is only ever raised for a valid requester, so any grant is a transfer.
    assign xfer         = |req_ready;
    assign pipe_data_in = xfer ? req_data[win_idx] : held;
    assign resp_data    = pipe_data_out;

    always_comb begin
        resp_valid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            resp_valid[i] = v[DEPTH-1] & (own[DEPTH-1] == TW'(i)) & ~flush;
        end
    end

    // Valid/owner shift, held in place while the head waits on its owner.
    always_comb begin
        v_nxt   = v;
        own_nxt = own;
        if (flush) begin
            v_nxt = '0;
        end else if (!pipe_stall) begin
            for (int k = int'(DEPTH) - 1; k > 0; k--) begin
                v_nxt[k]   = v[k-1];
                own_nxt[k] = own[k-1];
            end
            v_nxt[0] = xfer;
            if (xfer) begin
                own_nxt[0] = win_idx;
            end
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            cnt_nxt = cnt_nxt + CW'(v_nxt[k]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v        <= '0;
            own      <= '0;
            rr       <= TW'(NREQ - 1);
            held     <= '0;
            inflight <= '0;
            state    <= RUN;
            drained  <= 1'b0;
        end else begin
            v        <= v_nxt;
            own      <= own_nxt;
            inflight <= cnt_nxt;
            if (xfer) begin
                rr   <= win_idx;
                held <= req_data[win_idx];
            end
            // Drained is reached on the edge where the last valid bit leaves.
            case (state)
                RUN: begin
                    drained <= 1'b0;
                    if (drain_req) begin
                        state <= DRAINING;
                    end
                end
                DRAINING: begin
                    if (!drain_req) begin
                        state   <= RUN;
                        drained <= 1'b0;
                    end else if (v_nxt == '0) begin
                        state   <= DRAINED;
                        drained <= 1'b1;
                    end
                end
                DRAINED: begin
                    if (!drain_req) begin
                        state   <= RUN;
                        drained <= 1'b0;
                    end
                end
                default: begin
                    state   <= RUN;
                    drained <= 1'b0;
                end
            endcase
        end
    end

endmodule
